// File: rtl/sdram_wr_fifo_if.sv
// Write-path bus between an upstream producer, the write FIFO and the SDRAM controller.
// slave = the FIFO itself; master = the environment driving it.
`timescale 1ns/1ps
interface sdram_wr_fifo_if #(
  parameter int AW = 20
);
  logic [AW-1:0] in_addr;
  logic [15:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_req;
  logic          wr_ack;

  modport slave (
    input  in_addr, in_data, in_valid, wr_ack,
    output in_ready, wr_addr, wr_data, wr_req
  );

  modport master (
    output in_addr, in_data, in_valid, wr_ack,
    input  in_ready, wr_addr, wr_data, wr_req
  );
endinterface

// File: rtl/sdram_wr_fifo.sv
// Circular-buffer write FIFO in front of the SDRAM controller write port.
// Optional stat_writes/stat_stalls counters are enabled with SDRAM_WR_FIFO_STATS_EN.
`timescale 1ns/1ps
module sdram_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  sdram_wr_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle
`ifdef SDRAM_WR_FIFO_STATS_EN
  ,
  output logic [15:0]            stat_writes,
  output logic [15:0]            stat_stalls
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          in_ready_q, in_ready_d;
  logic          empty, full_d, push, pop;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [15:0]   mem_data [DEPTH];

  // in_ready is computed from the next-state pointers so it never sees wr_ack combinationally.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    push       = bus.in_valid && in_ready_q;
    pop        = bus.wr_ack && !empty;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    full_d     = (wr_ptr_d[IW-1:0] == rd_ptr_d[IW-1:0]) && (wr_ptr_d[IW] != rd_ptr_d[IW]);
    in_ready_d = !full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q[IW-1:0]] <= bus.in_addr;
      mem_data[wr_ptr_q[IW-1:0]] <= bus.in_data;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_req   = !empty;
  assign bus.wr_addr  = mem_addr[rd_ptr_q[IW-1:0]];
  assign bus.wr_data  = mem_data[rd_ptr_q[IW-1:0]];
  assign level        = wr_ptr_q - rd_ptr_q;
  assign idle         = (level == '0) && !bus.wr_req;

`ifdef SDRAM_WR_FIFO_STATS_EN
  logic [15:0] stat_writes_q, stat_writes_d;
  logic [15:0] stat_stalls_q, stat_stalls_d;

  // Write count wraps; stall count saturates so long stalls stay visible.
  always_comb begin
    stat_writes_d = stat_writes_q + 16'(pop);
    stat_stalls_d = stat_stalls_q;
    if (bus.in_valid && !in_ready_q && (stat_stalls_q != 16'hFFFF)) begin
      stat_stalls_d = stat_stalls_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_writes_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_writes_q <= stat_writes_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_writes = stat_writes_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_sdram_wr_fifo.sv
// Randomized self-checking bench for sdram_wr_fifo against a queue-based reference model.
// Stats checks are compiled in when SDRAM_WR_FIFO_STATS_EN is defined.
`timescale 1ns/1ps
module tb_sdram_wr_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] level;
  logic       idle;
  int         n_cmp = 0;
  int         n_fail = 0;

  sdram_wr_fifo_if #(.AW(AW)) bus ();

`ifdef SDRAM_WR_FIFO_STATS_EN
  logic [15:0] stat_writes, stat_stalls;
  sdram_wr_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .level(level), .idle(idle),
    .stat_writes(stat_writes), .stat_stalls(stat_stalls));
`else
  sdram_wr_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .level(level), .idle(idle));
`endif

  always #5 clk = ~clk;

  // Reference model: a plain queue of {addr,data}, with the registered-ready rule
  logic [AW+15:0] mq[$];
  bit             m_ready = 1'b1;
  bit             m_push, m_pop;
  logic [15:0]    m_writes = '0;
  logic [15:0]    m_stalls = '0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_ready  = 1'b1;
      m_writes = '0;
      m_stalls = '0;
    end else begin
      m_push = bus.in_valid && m_ready;
      m_pop  = bus.wr_ack && (mq.size() > 0);
      if (bus.in_valid && !m_ready && m_stalls != 16'hFFFF) m_stalls = m_stalls + 16'd1;
      if (m_pop) begin
        void'(mq.pop_front());
        m_writes = m_writes + 16'd1;
      end
      if (m_push) mq.push_back({bus.in_addr, bus.in_data});
      m_ready = (mq.size() < DEPTH);
    end
  end

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.wr_ack = 1'b0;
    bus.in_addr = '0;
    bus.in_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
    n_cmp++; if (bus.wr_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_req got=%b exp=0", bus.wr_req); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_idle got=%b exp=1", idle); end
  endtask

  task automatic test_single_write();
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_addr = 20'h000F0;
    bus.in_data = 16'h1234;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.wr_req !== 1'b1) begin n_fail++; $display("[TB] FAIL single_wr_req got=%b exp=1", bus.wr_req); end
    n_cmp++; if (bus.wr_addr !== 20'h000F0) begin n_fail++; $display("[TB] FAIL single_addr got=%h exp=000f0", bus.wr_addr); end
    n_cmp++; if (bus.wr_data !== 16'h1234) begin n_fail++; $display("[TB] FAIL single_data got=%h exp=1234", bus.wr_data); end
    bus.wr_ack = 1'b1;
    @(negedge clk);
    bus.wr_ack = 1'b0;
    n_cmp++; if (bus.wr_req !== 1'b0) begin n_fail++; $display("[TB] FAIL single_req_drop got=%b exp=0", bus.wr_req); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("[TB] FAIL single_idle got=%b exp=1", idle); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr = 20'($urandom);
      bus.in_data = 16'($urandom);
      @(negedge clk);
    end
    n_cmp++; if (level !== 4'd8) begin n_fail++; $display("[TB] FAIL fill_level got=%0d exp=8", level); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
    n_cmp++; if ({bus.wr_addr, bus.wr_data} !== mq[0]) begin n_fail++; $display("[TB] FAIL fill_head got=%h exp=%h", {bus.wr_addr, bus.wr_data}, mq[0]); end
`ifdef SDRAM_WR_FIFO_STATS_EN
    n_cmp++; if (stat_stalls !== 16'd3) begin n_fail++; $display("[TB] FAIL fill_stalls got=%0d exp=3", stat_stalls); end
`endif
  endtask

  // Runs directly after test_fill, with the FIFO full and in_valid still asserted
  task automatic test_full_pop();
    bus.wr_ack = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 16'hBEEF;
    @(negedge clk);
    bus.wr_ack = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++; if (level !== 4'd7) begin n_fail++; $display("[TB] FAIL fullpop_level got=%0d exp=7", level); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fullpop_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if ({bus.wr_addr, bus.wr_data} !== mq[0]) begin n_fail++; $display("[TB] FAIL fullpop_head got=%h exp=%h", {bus.wr_addr, bus.wr_data}, mq[0]); end
  endtask

  task automatic test_simultaneous();
    logic [AW+15:0] second;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr = 20'(32'h100 + i);
      bus.in_data = 16'(32'hA000 + i);
      @(negedge clk);
    end
    n_cmp++; if (level !== 4'd3) begin n_fail++; $display("[TB] FAIL simul_pre_level got=%0d exp=3", level); end
    second = {20'h00101, 16'hA001};
    bus.in_addr = 20'h00200;
    bus.in_data = 16'h5555;
    bus.wr_ack = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.wr_ack = 1'b0;
    n_cmp++; if (level !== 4'd3) begin n_fail++; $display("[TB] FAIL simul_level got=%0d exp=3", level); end
    n_cmp++; if ({bus.wr_addr, bus.wr_data} !== second) begin n_fail++; $display("[TB] FAIL simul_head got=%h exp=%h", {bus.wr_addr, bus.wr_data}, second); end
  endtask

  task automatic test_order_wrap();
    logic [15:0] exp_data [32];
    logic [31:0] x;
    int sent, got, cyc;
    bit acc;
    do_reset();
    x = 32'h1;
    for (int i = 0; i < 32; i++) begin
      x = xorshift32(x);
      exp_data[i] = x[15:0];
    end
    sent = 0; got = 0; cyc = 0; acc = 1'b0;
    while (got < 32 && cyc < 2000) begin
      if (acc) sent++;
      n_cmp++; if (level !== 4'(mq.size())) begin n_fail++; $display("[TB] FAIL order_level got=%0d exp=%0d", level, mq.size()); end
      n_cmp++; if (bus.in_ready !== m_ready) begin n_fail++; $display("[TB] FAIL order_in_ready got=%b exp=%b", bus.in_ready, m_ready); end
      bus.wr_ack = 1'b0;
      if ((cyc % 3) == 2 && bus.wr_req === 1'b1) begin
        n_cmp++;
        if (bus.wr_addr !== 20'(32'hF0 + got) || bus.wr_data !== exp_data[got]) begin
          n_fail++;
          $display("[TB] FAIL order_entry%0d got=%h/%h exp=%h/%h", got, bus.wr_addr, bus.wr_data, 20'(32'hF0 + got), exp_data[got]);
        end
        bus.wr_ack = 1'b1;
        got++;
      end
      if (sent < 32) begin
        bus.in_valid = 1'b1;
        bus.in_addr = 20'(32'hF0 + sent);
        bus.in_data = exp_data[sent];
        acc = bus.in_ready;
      end else begin
        bus.in_valid = 1'b0;
        acc = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.wr_ack = 1'b0;
    n_cmp++; if (got != 32) begin n_fail++; $display("[TB] FAIL order_timeout got=%0d exp=32", got); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      n_cmp++; if (level !== 4'(mq.size())) begin n_fail++; $display("[TB] FAIL rand_level got=%0d exp=%0d", level, mq.size()); end
      n_cmp++; if (bus.wr_req !== (mq.size() != 0)) begin n_fail++; $display("[TB] FAIL rand_wr_req got=%b exp=%b", bus.wr_req, mq.size() != 0); end
      n_cmp++; if (bus.in_ready !== m_ready) begin n_fail++; $display("[TB] FAIL rand_in_ready got=%b exp=%b", bus.in_ready, m_ready); end
      n_cmp++; if (idle !== (mq.size() == 0)) begin n_fail++; $display("[TB] FAIL rand_idle got=%b exp=%b", idle, mq.size() == 0); end
      if (mq.size() != 0) begin
        n_cmp++; if ({bus.wr_addr, bus.wr_data} !== mq[0]) begin n_fail++; $display("[TB] FAIL rand_head got=%h exp=%h", {bus.wr_addr, bus.wr_data}, mq[0]); end
      end
`ifdef SDRAM_WR_FIFO_STATS_EN
      n_cmp++; if (stat_writes !== m_writes) begin n_fail++; $display("[TB] FAIL rand_stat_writes got=%0d exp=%0d", stat_writes, m_writes); end
      n_cmp++; if (stat_stalls !== m_stalls) begin n_fail++; $display("[TB] FAIL rand_stat_stalls got=%0d exp=%0d", stat_stalls, m_stalls); end
`endif
      bus.in_valid = ($urandom_range(0, 99) < 60);
      bus.wr_ack   = ($urandom_range(0, 99) < 45);
      bus.in_addr  = 20'($urandom);
      bus.in_data  = 16'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.wr_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr = 20'($urandom);
      bus.in_data = 16'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (level !== 4'd5) begin n_fail++; $display("[TB] FAIL mid_pre_level got=%0d exp=5", level); end
    n_cmp++; if (bus.wr_req !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pre_wr_req got=%b exp=1", bus.wr_req); end
    reset = 1'b1;
    bus.wr_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.wr_ack = 1'b0;
    n_cmp++; if (bus.wr_req !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_wr_req got=%b exp=0", bus.wr_req); end
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("[TB] FAIL mid_level got=%0d exp=0", level); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
`ifdef SDRAM_WR_FIFO_STATS_EN
    n_cmp++; if (stat_writes !== 16'd0) begin n_fail++; $display("[TB] FAIL mid_stat_writes got=%0d exp=0", stat_writes); end
    n_cmp++; if (stat_stalls !== 16'd0) begin n_fail++; $display("[TB] FAIL mid_stat_stalls got=%0d exp=0", stat_stalls); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.wr_ack = 1'b0;
    bus.in_addr = '0;
    bus.in_data = '0;
    test_reset();
    test_single_write();
    test_fill();
    test_full_pop();
    test_simultaneous();
    test_order_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_wr_fifo.md
SDRAM_WR_FIFO -- requirements
Module: sdram_wr_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; SHALL be a power of two, 2..64.
REQ-002 Parameter AW, default 20, word address width; SHALL match the controller wr_addr width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_addr  input  AW  upstream write word address.
REQ-006 in_data  input  16  upstream write data.
REQ-007 in_valid  input  1  upstream write present.
REQ-008 in_ready  output  1  FIFO can accept; transfer on in_valid && in_ready.
REQ-009 wr_addr  output  AW  to controller, head entry address.
REQ-010 wr_data  output  16  to controller, head entry data.
REQ-011 wr_req  output  1  to controller, head entry valid.
REQ-012 wr_ack  input  1  from controller, one-cycle pulse, head entry consumed.
REQ-013 level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 idle  output  1  high when level==0 and wr_req==0.

Function
REQ-015 Storage SHALL be a circular buffer: rd_ptr and wr_ptr of $clog2(DEPTH)+1 bits; full when indices match and MSBs differ; empty when pointers are equal.
REQ-016 in_ready SHALL be a registered !full; it SHALL NOT depend combinationally on wr_ack.
REQ-017 A push SHALL occur on in_valid && in_ready: entry written at wr_ptr[idx]; wr_ptr increments modulo 2*DEPTH.
REQ-018 wr_req SHALL equal !empty; wr_addr and wr_data SHALL equal the head entry and stay stable while wr_req is high and wr_ack is low.
REQ-019 A pop SHALL occur on wr_ack && wr_req: rd_ptr increments; the next entry appears on wr_addr/wr_data in the following cycle, with wr_req held high if the FIFO is still non-empty.
REQ-020 wr_ack while wr_req is low SHALL be ignored; no pointer change.
REQ-021 Latency: a push into an empty FIFO at edge N SHALL raise wr_req after edge N; data is visible in the cycle following acceptance.
REQ-022 Simultaneous push and pop SHALL update both pointers; level unchanged.
REQ-023 When full, in_ready is low; a same-cycle pop SHALL NOT admit a push that cycle; in_ready rises in the next cycle.
REQ-024 level SHALL equal wr_ptr - rd_ptr (modulo 2*DEPTH) and never exceed DEPTH.
REQ-025 Entry order SHALL be strictly preserved; no combining or reordering.
REQ-026 Pointer wrap SHALL be seamless across index DEPTH-1 -> 0.

Reset
REQ-027 On reset: rd_ptr=wr_ptr=0, wr_req=0, level=0, in_ready=1 in the cycle after release, idle=1; buffered entries are discarded.
REQ-028 Reset asserted mid-transfer SHALL drop wr_req the next cycle regardless of wr_ack; the controller is reset together with this block.
REQ-029 Storage RAM contents SHALL NOT require reset.

Configuration
REQ-030 Macro SDRAM_WR_FIFO_STATS_EN: when defined, adds outputs stat_writes[15:0] and stat_stalls[15:0].
REQ-031 stat_writes SHALL increment on each pop and wrap at 16'hFFFF->0.
REQ-032 stat_stalls SHALL increment each cycle with in_valid && !in_ready and saturate at 16'hFFFF.
REQ-033 Both stats counters SHALL clear on reset.
REQ-034 Without the macro, the stats ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 Single write: reset, then push addr 20'h000F0 data 16'h1234 -> wr_req high next cycle with wr_addr=20'h000F0, wr_data=16'h1234; wr_ack -> wr_req low next cycle, idle=1.
REQ-036 Fill: 8 pushes with wr_ack held low (DEPTH=8) -> level=8, in_ready=0; 9th in_valid stalls; with STATS_EN, stat_stalls increments per stalled cycle.
REQ-037 Order/wrap: 32 pushes of xorshift32 data to addresses 20'hF0..20'h10F with wr_ack every 3rd cycle -> controller sees all 32 in order, data matches regenerated sequence, pointers wrap 4 times.
REQ-038 Full plus pop: at level=8, pulse wr_ack -> level=7 and in_ready=1 in the next cycle, no push accepted in the ack cycle.
REQ-039 Simultaneous: at level=3, push and wr_ack in the same cycle -> level stays 3 and head advances.
REQ-040 Reset mid-operation: level=5 with wr_req high, assert reset one cycle -> wr_req=0, level=0, in_ready=1; stats counters read 0.
